// File: rtl/ssd_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Holds FSM encoding, widths, segment patterns and the double-dabble adjust.
package ssd_pkg;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 13;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles render blank.
import ssd_pkg::*;

module seg7_decode (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scanner.sv
// Binary-to-BCD converter feeding a multiplexed 4-digit LED display.
// Define SSD_LEADING_BLANK_EN to blank zeros above the top nonzero digit.
import ssd_pkg::*;

module ssd_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] num_in,
    input  logic             load,
    output logic             busy,
    output logic [3:0]       anode,
    output logic [6:0]       cathode
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] r_disp;
    logic [3:0]       r_step;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_on;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic             w_lead;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (load) w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_step == 4'd12) w_state_nxt = S_UPDATE;
            S_UPDATE:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign w_adj = dd_adjust(r_bcd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_step <= '0;
            r_disp <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (load) begin
                    r_bin  <= num_in;
                    r_bcd  <= '0;
                    r_step <= '0;
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_step         <= r_step + 4'd1;
                end
                S_UPDATE: r_disp <= r_bcd;
                default: ;
            endcase
        end
    end

    // Scan runs free of the FSM; r_on keeps outputs dark until the first edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_on  <= 1'b0;
        end else begin
            r_on <= 1'b1;
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SSD_LEADING_BLANK_EN
    assign w_lead = (r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == '0);
`else
    assign w_lead = 1'b0;
`endif

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    assign anode   = r_on ? ~(4'b0001 << r_idx) : 4'b1111;
    assign cathode = (r_on && !w_lead) ? w_seg : SEG_BLANK;

endmodule

// File: tb/tb_ssd_scanner.sv
// Directed and random stimulus for ssd_scanner, checked every cycle
// against an arithmetic model of busy timing, display value and scan.
module tb_ssd_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [12:0] num_in = '0;
    logic        busy;
    logic [3:0]  anode;
    logic [6:0]  cathode;

    ssd_scanner #(.REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .num_in  (num_in),
        .load    (load),
        .busy    (busy),
        .anode   (anode),
        .cathode (cathode)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    int m_disp = 0;
    int m_pend = 0;
    int m_cnt  = 0;
    int k      = 0;
    bit m_busy = 0;
    bit m_rst  = 1;

    logic [6:0] segtab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    int pw [4] = '{1, 10, 100, 1000};

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int cur_idx();
        return (k / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_anode();
        logic [3:0] a;
        if (m_rst || k == 0) return 4'b1111;
        a = 4'b1111;
        a[cur_idx()] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_cath();
        int idx;
        if (m_rst || k == 0) return 7'b1111111;
        idx = cur_idx();
`ifdef SSD_LEADING_BLANK_EN
        if (idx > 0 && m_disp < pw[idx]) return 7'b1111111;
`endif
        return segtab[(m_disp / pw[idx]) % 10];
    endfunction

    task automatic check_outs();
        check("busy", 16'(busy), 16'(m_busy));
        check("anode", 16'(anode), 16'(exp_anode()));
        check("cathode", 16'(cathode), 16'(exp_cath()));
    endtask

    task automatic tick();
        bit acc;
        int val;
        acc = load && !m_busy && !m_rst;
        val = int'(num_in);
        @(posedge clk);
        #1;
        if (!m_rst) begin
            k++;
            if (acc) begin
                m_busy = 1;
                m_cnt  = 0;
                m_pend = val;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == 14) begin
                    m_busy = 0;
                    m_disp = m_pend;
                end
            end
        end
        check_outs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int v);
        num_in = 13'(v);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        num_in = 13'($urandom);
    endtask

    task automatic assert_reset();
        rst    = 1'b0;
        m_rst  = 1;
        m_busy = 0;
        m_disp = 0;
        k      = 0;
        #1;
        check_outs();
    endtask

    task automatic release_reset();
        rst   = 1'b1;
        m_rst = 0;
        k     = 0;
    endtask

    initial begin
        int n;
        assert_reset();
        run(2);
        release_reset();
        run(20);

        do_load(1234);
        n = 1;
        while (busy && n < 100) begin
            tick();
            if (busy) n++;
        end
        check("busy_len", 16'(n), 16'd14);
        run(16);

        do_load(8191);
        run(1);
        do_load(5);
        run(30);

        do_load(4321);
        run(6);
        assert_reset();
        run(3);
        release_reset();
        run(20);

        do_load(7);
        run(30);
        do_load(0);
        run(30);

        for (int r = 0; r < 12; r++) begin
            run($urandom_range(0, 12));
            do_load($urandom_range(0, 8191));
            if ($urandom_range(0, 2) == 0) begin
                run($urandom_range(0, 10));
                do_load($urandom_range(0, 8191));
            end
            run(18);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
